fp_adder_collector: RTL and testbench

//  Downstream companion of the pipelined FP_Adder. Tracks issued operand pairs through the

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_result_fifo.sv | 73 +++++++
 rtl/fp_adder_collector.sv | 97 +++++++++
 tb/tb_fp_adder_collector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP word geometry, adder latency and zero-detect helper
package fp_pkg;

  localparam int FP_SIZE          = 32;
  localparam int FRAC_SIZE        = 23;
  localparam int EXP_SIZE         = 8;
  localparam int FP_ADDER_LATENCY = 4;

  // True for +0 and -0: every bit below the sign bit is clear.
  // The word is passed zero-extended to 64 bits so any width up to 64 can share it.
  function automatic logic fp_is_zero(input logic [63:0] word, input int width);
    logic [63:0] mask;
    mask = (64'd1 << (width - 1)) - 64'd1;
    return (word & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// rtl/fp_result_fifo.sv - ring-buffer FIFO with a registered head word (no fall-through)
module fp_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mcnt_q, mcnt_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             push_ok;
  logic             pop_ok;
  logic             load;

  // Ring-buffer bookkeeping; the head register refills from the ring whenever it is
  // empty or being popped, so a word written this edge shows at the head one edge later.
  always_comb begin
    full         = (mcnt_q == (AW+1)'(DEPTH));
    pop_ok       = pop & head_valid_q;
    push_ok      = push & ~full;
    load         = (mcnt_q != '0) & (~head_valid_q | pop_ok);
    mem_d        = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
    end
    wr_ptr_d     = wr_ptr_q + AW'(push_ok);
    rd_ptr_d     = rd_ptr_q + AW'(load);
    mcnt_d       = mcnt_q + (AW+1)'(push_ok) - (AW+1)'(load);
    head_valid_d = load | (head_valid_q & ~pop_ok);
    head_data_d  = load ? mem_q[rd_ptr_q] : head_data_q;
  end

  // State registers; reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mcnt_q       <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mcnt_q       <= mcnt_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign out_data = head_data_q;
  assign empty    = ~head_valid_q;
  assign count    = CW'(mcnt_q) + CW'(head_valid_q);

endmodule

// File: rtl/fp_adder_collector.sv
// rtl/fp_adder_collector.sv - tracks FP_Adder issues with tokens and buffers results under credit control
module fp_adder_collector #(
  parameter int FP_SIZE = fp_pkg::FP_SIZE,
  parameter int LATENCY = fp_pkg::FP_ADDER_LATENCY,
  parameter int DEPTH   = 4,
  localparam int OCC_W  = $clog2(DEPTH + LATENCY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in_valid,
  output logic               issue_ready,
  output logic               adder_valid,
  input  logic [FP_SIZE-1:0] adder_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_SIZE-1:0] out_data,
  output logic               out_zero,
  output logic [OCC_W-1:0]   occupancy,
  output logic               overflow_err
);

  localparam int CNT_W = $clog2(DEPTH + 2);

  logic [LATENCY-1:1] tok_q, tok_d;
  logic               en_prev_q, en_prev_d;
  logic               tok_last_q, tok_last_d;
  logic [OCC_W-1:0]   inflight_q, inflight_d;
  logic               overflow_q, overflow_d;
  logic               fire;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Credits come only from registered counts, so issue_ready never depends on in_valid.
  assign occupancy   = inflight_q + OCC_W'(fifo_count);
  assign issue_ready = (occupancy < OCC_W'(DEPTH));
  assign adder_valid = in_valid & issue_ready;
  assign fire        = adder_valid & enable;
  assign push        = tok_last_q;
  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;

  // Token pipe mirrors the adder: enable-gated stages, then a free-running output stage
  // that fires once per token, only when the previous edge actually advanced the pipe.
  always_comb begin
    tok_d = tok_q;
    if (enable) begin
      tok_d[1] = fire;
      for (int i = 2; i < LATENCY; i++) begin
        tok_d[i] = tok_q[i-1];
      end
    end
    en_prev_d  = enable;
    tok_last_d = tok_q[LATENCY-1] & en_prev_q;
    inflight_d = inflight_q + OCC_W'(fire) - OCC_W'(push);
    overflow_d = overflow_q | (push & fifo_full);
  end

  // Token, credit and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_q      <= '0;
      en_prev_q  <= 1'b0;
      tok_last_q <= 1'b0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      tok_q      <= tok_d;
      en_prev_q  <= en_prev_d;
      tok_last_q <= tok_last_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  fp_result_fifo #(
    .WIDTH (FP_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (adder_result),
    .pop       (pop),
    .out_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_zero     = fp_pkg::fp_is_zero(64'(out_data), FP_SIZE);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fp_adder_collector.sv
// tb/tb_fp_adder_collector.sv - self-checking bench for fp_adder_collector
module tb_fp_adder_collector;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_res = 32'h0;
  logic [31:0] seq_q = 32'h0;
  logic [31:0] pair_result;

  logic        issue_ready, adder_valid, out_valid, out_zero, overflow_err;
  logic [31:0] adder_result, out_data;
  logic [3:0]  occupancy;

  logic [31:0] s1, s2, s3, r_out;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  int checks = 0;
  int failures = 0;

  fp_adder_collector #(.FP_SIZE(32), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_valid     (in_valid),
    .issue_ready  (issue_ready),
    .adder_valid  (adder_valid),
    .adder_result (adder_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero     (out_zero),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  assign pair_result  = use_fixed ? fixed_res : (32'h5A00_0000 | seq_q);
  assign adder_result = r_out;

  // Adder stand-in: three enable-gated stages and a free-running output register.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0; s2 <= '0; s3 <= '0; r_out <= '0;
    end else begin
      if (enable) begin
        s1 <= adder_valid ? pair_result : 32'h0;
        s2 <= s1;
        s3 <= s2;
      end
      r_out <= s3;
    end
  end

  // Scoreboard feed: expected word on every issue, observed word on every pop.
  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && issue_ready && enable) begin
        exp_q.push_back(pair_result);
        seq_q <= seq_q + 32'd1;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    rst = 1'b0; enable = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b want=1", out_valid); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    checks++;
    if (out_zero !== 1'b1) begin failures++; $display("FAIL rst_out_zero got=%b want=1", out_zero); end
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL rst_occupancy got=%0d want=0", occupancy); end
    checks++;
    if (overflow_err !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b want=0", overflow_err); end
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL rst_issue_ready got=%b want=1", issue_ready); end
    @(posedge clk);
    #3 rst = 1'b0;
    clear_sb();
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL post_rst_issue_ready got=%b want=1", issue_ready); end
  endtask

  task automatic test_single();
    int n;
    logic found;
    tick();
    use_fixed = 1'b1; fixed_res = 32'h4040_0000; out_ready = 1'b1; enable = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0; found = 1'b0;
    while (n < 20 && !found) begin
      tick();
      n++;
      if (out_valid) found = 1'b1;
    end
    checks++;
    if (!found || n != LAT + 1) begin failures++; $display("FAIL single_latency got=%0d want=%0d", n, LAT + 1); end
    checks++;
    if (out_data !== 32'h4040_0000) begin failures++; $display("FAIL single_data got=%h want=40400000", out_data); end
    checks++;
    if (out_zero !== 1'b0) begin failures++; $display("FAIL single_zero got=%b want=0", out_zero); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b want=0", out_valid); end
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL single_scoreboard got_n=%0d want_n=1", got_q.size());
    end
    clear_sb();
    use_fixed = 1'b0;
  endtask

  task automatic test_backpressure();
    int fires;
    logic resumed;
    logic [31:0] g, e;
    out_ready = 1'b0; enable = 1'b1; in_valid = 1'b1;
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      if (issue_ready) fires++;
      tick();
    end
    checks++;
    if (fires != DEPTH) begin failures++; $display("FAIL bp_fires got=%0d want=%0d", fires, DEPTH); end
    checks++;
    if (occupancy !== 4'(DEPTH)) begin failures++; $display("FAIL bp_occupancy got=%0d want=%0d", occupancy, DEPTH); end
    checks++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL bp_issue_ready got=%b want=0", issue_ready); end
    out_ready = 1'b1;
    resumed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (issue_ready) resumed = 1'b1;
      tick();
    end
    checks++;
    if (!resumed) begin failures++; $display("FAIL bp_resume got=0 want=1"); end
    in_valid = 1'b0;
    repeat (20) tick();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < DEPTH) begin
      failures++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL bp_order got=%h want=%h", g, e); end
    end
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL bp_final_occ got=%0d want=0", occupancy); end
    clear_sb();
  endtask

  task automatic test_enable_stall();
    out_ready = 1'b1; enable = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    repeat (10) tick();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      failures++; $display("FAIL stall_single_push got=%0d want=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL stall_data got=%h want=%h", got_q[0], exp_q[0]); end
    end
    checks++;
    if (overflow_err !== 1'b0) begin failures++; $display("FAIL stall_overflow got=%b want=0", overflow_err); end
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL stall_occupancy got=%0d want=0", occupancy); end
    clear_sb();
  endtask

  task automatic test_continuous();
    int max_occ;
    logic [31:0] g, e;
    out_ready = 1'b1; enable = 1'b1; in_valid = 1'b1;
    max_occ = 0;
    for (int i = 0; i < 60; i++) begin
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      tick();
    end
    in_valid = 1'b0;
    repeat (15) tick();
    checks++;
    if (max_occ > DEPTH) begin failures++; $display("FAIL cont_max_occ got=%0d want<=%0d", max_occ, DEPTH); end
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < 12) begin
      failures++; $display("FAIL cont_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL cont_order got=%h want=%h", g, e); end
    end
    checks++;
    if (overflow_err !== 1'b0) begin failures++; $display("FAIL cont_overflow got=%b want=0", overflow_err); end
    clear_sb();
  endtask

  task automatic test_zero_and_reset();
    int n;
    logic stale;
    use_fixed = 1'b1; fixed_res = 32'h8000_0000;
    out_ready = 1'b0; enable = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (n < 20 && !out_valid) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%b want=1", out_valid); end
    checks++;
    if (out_data !== 32'h8000_0000) begin failures++; $display("FAIL zero_data got=%h want=80000000", out_data); end
    checks++;
    if (out_zero !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b want=1", out_zero); end
    fixed_res = 32'h3F80_0000;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (occupancy !== 4'd3) begin failures++; $display("FAIL mid_occupancy got=%0d want=3", occupancy); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    @(posedge clk);
    #3 rst = 1'b0;
    clear_sb();
    use_fixed = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin failures++; $display("FAIL stale_valid got=1 want=0"); end
    checks++;
    if (occupancy !== 4'd0) begin failures++; $display("FAIL post_rst_occupancy got=%0d want=0", occupancy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_enable_stall();
    test_continuous();
    test_zero_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
